// File: rtl/serial_eq_sequencer_if.sv
// Request/result bundle for serial_eq_sequencer: compare command in, wide equality result out.
interface serial_eq_sequencer_if #(
    parameter int WIDTH = 8
);
    localparam int N  = WIDTH / 2;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             res_valid;
    logic             res_ready;
    logic             res_eq;
    logic [IW-1:0]    res_idx;
    logic             busy;

    modport master (
        output start_valid, op_a, op_b, res_ready,
        input  start_ready, res_valid, res_eq, res_idx, busy
    );

    modport slave (
        input  start_valid, op_a, op_b, res_ready,
        output start_ready, res_valid, res_eq, res_idx, busy
    );
endinterface

// File: rtl/serial_eq_sequencer.sv
// Walks one 2-bit equality slice across a WIDTH-bit operand pair, LSB slice first.
// Optional macro SERIAL_EQ_EARLY_EXIT_EN: stop scanning at the first mismatching slice.
//
// state | meaning
// IDLE  | ready for a request, last result held
// RUN   | comparing slice k of the captured operands
// DONE  | result presented until the consumer takes it
module serial_eq_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_eq_sequencer_if.slave  bus
);
    localparam int N  = WIDTH / 2;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_k;
    logic             r_eq_acc;
    logic             r_mism;
    logic             r_res_eq;
    logic [IW-1:0]    r_res_idx;

    logic [1:0]       w_slice_a;
    logic [1:0]       w_slice_b;
    logic             w_slice_eq;
    logic             w_last_slice;
    logic             w_run_done;
    logic             w_accept;

    assign w_slice_a    = 2'(r_a >> {r_k, 1'b0});
    assign w_slice_b    = 2'(r_b >> {r_k, 1'b0});
    assign w_slice_eq   = (w_slice_a == w_slice_b);
    assign w_last_slice = (r_k == IW'(N - 1));
    assign w_accept     = (r_state == ST_IDLE) && bus.start_valid;

`ifdef SERIAL_EQ_EARLY_EXIT_EN
    assign w_run_done = w_last_slice || !w_slice_eq;
`else
    assign w_run_done = w_last_slice;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        bus.start_ready = 1'b0;
        bus.res_valid   = 1'b0;
        bus.busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.start_ready = 1'b1;
                if (bus.start_valid) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                bus.busy = 1'b1;
                if (w_run_done) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.busy      = 1'b1;
                bus.res_valid = 1'b1;
                if (bus.res_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Result registers only move on acceptance or during RUN, so they hold through DONE and IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_k       <= '0;
            r_eq_acc  <= 1'b0;
            r_mism    <= 1'b0;
            r_res_eq  <= 1'b0;
            r_res_idx <= '0;
        end else if (w_accept) begin
            r_a       <= bus.op_a;
            r_b       <= bus.op_b;
            r_k       <= '0;
            r_eq_acc  <= 1'b1;
            r_mism    <= 1'b0;
            r_res_eq  <= 1'b0;
            r_res_idx <= '0;
        end else if (r_state == ST_RUN) begin
            r_eq_acc <= r_eq_acc & w_slice_eq;
            if (!w_slice_eq && !r_mism) begin
                r_res_idx <= r_k;
                r_mism    <= 1'b1;
            end
            if (w_run_done) begin
                r_res_eq <= r_eq_acc & w_slice_eq;
            end else begin
                r_k <= r_k + IW'(1);
            end
        end
    end

    assign bus.res_eq  = r_res_eq;
    assign bus.res_idx = r_res_idx;
endmodule

// File: tb/tb_serial_eq_sequencer.sv
// Scoreboard bench for serial_eq_sequencer at WIDTH=8 and WIDTH=2.
module tb_serial_eq_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_eq_sequencer_if #(.WIDTH(8)) bus8();
    serial_eq_sequencer_if #(.WIDTH(2)) bus2();

    serial_eq_sequencer #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_eq_sequencer #(.WIDTH(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    typedef struct {
        logic eq;
        int   idx;
        int   lat;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int n, input logic [7:0] a, input logic [7:0] b);
        exp_t       e;
        logic [7:0] sa;
        logic [7:0] sb;
        e.eq  = 1'b1;
        e.idx = 0;
        e.lat = n;
        for (int i = 0; i < n; i++) begin
            sa = (a >> (2 * i)) & 8'd3;
            sb = (b >> (2 * i)) & 8'd3;
            if (sa != sb && e.eq) begin
                e.eq  = 1'b0;
                e.idx = i;
`ifdef SERIAL_EQ_EARLY_EXIT_EN
                e.lat = i + 1;
`endif
            end
        end
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue on bus8, wait for the result, compare against the scoreboard; leaves result pending.
    task automatic run8(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   lat;
        chk("rdy8", bus8.start_ready, 1);
        bus8.op_a        = a;
        bus8.op_b        = b;
        bus8.start_valid = 1'b1;
        tick();
        bus8.start_valid = 1'b0;
        sb_q.push_back(model(4, a, b));
        chk("busy8", bus8.busy, 1);
        lat = 0;
        while (!bus8.res_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk("val8", bus8.res_valid, 1);
        e = sb_q.pop_front();
        last_exp = e;
        chk("eq8", bus8.res_eq, e.eq);
        chk("idx8", bus8.res_idx, e.idx);
        chk("lat8", lat, e.lat);
    endtask

    task automatic take8;
        bus8.res_ready = 1'b1;
        tick();
        bus8.res_ready = 1'b0;
        chk("clr8", bus8.res_valid, 0);
        chk("idle8", bus8.start_ready, 1);
        chk("nbusy8", bus8.busy, 0);
        chk("hold_eq8", bus8.res_eq, last_exp.eq);
    endtask

    task automatic run2(input logic [1:0] a, input logic [1:0] b);
        exp_t e;
        int   lat;
        chk("rdy2", bus2.start_ready, 1);
        bus2.op_a        = a;
        bus2.op_b        = b;
        bus2.start_valid = 1'b1;
        tick();
        bus2.start_valid = 1'b0;
        sb_q.push_back(model(1, {6'd0, a}, {6'd0, b}));
        lat = 0;
        while (!bus2.res_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("val2", bus2.res_valid, 1);
        e = sb_q.pop_front();
        chk("eq2", bus2.res_eq, e.eq);
        chk("idx2", bus2.res_idx, e.idx);
        chk("lat2", lat, e.lat);
        bus2.res_ready = 1'b1;
        tick();
        bus2.res_ready = 1'b0;
        chk("clr2", bus2.res_valid, 0);
    endtask

    initial begin
        rst_n            = 1'b0;
        bus8.start_valid = 1'b1;
        bus8.op_a        = 8'hFF;
        bus8.op_b        = 8'h00;
        bus8.res_ready   = 1'b0;
        bus2.start_valid = 1'b0;
        bus2.op_a        = 2'd0;
        bus2.op_b        = 2'd0;
        bus2.res_ready   = 1'b0;
        repeat (3) tick();
        chk("rst_rdy", bus8.start_ready, 1);
        chk("rst_val", bus8.res_valid, 0);
        chk("rst_eq", bus8.res_eq, 0);
        chk("rst_idx", bus8.res_idx, 0);
        chk("rst_busy", bus8.busy, 0);
        chk("rst_rdy2", bus2.start_ready, 1);
        bus8.start_valid = 1'b0;
        rst_n            = 1'b1;
        tick();

        run8(8'hA5, 8'hA5); take8();
        run8(8'hA5, 8'hA4); take8();
        run8(8'h00, 8'h44); take8();
        run8(8'h00, 8'h80); take8();
        for (int i = 0; i < 6; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = (i % 2 == 0) ? ra : 8'($urandom);
            run8(ra, rb);
            take8();
        end

        // Back-pressure: result must hold and new requests must be refused.
        run8(8'h3C, 8'h30);
        for (int i = 0; i < 5; i++) begin
            bus8.op_a        = 8'($urandom);
            bus8.op_b        = 8'($urandom);
            bus8.start_valid = 1'b1;
            tick();
            chk("bp_val", bus8.res_valid, 1);
            chk("bp_eq", bus8.res_eq, last_exp.eq);
            chk("bp_idx", bus8.res_idx, last_exp.idx);
            chk("bp_rdy", bus8.start_ready, 0);
        end
        bus8.start_valid = 1'b0;
        take8();
        run8(8'h12, 8'h12); take8();

        // Reset while RUN at k=2 discards the compare.
        bus8.op_a        = 8'h5A;
        bus8.op_b        = 8'h5A;
        bus8.start_valid = 1'b1;
        tick();
        bus8.start_valid = 1'b0;
        repeat (2) tick();
        chk("mid_busy", bus8.busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("ab_rdy", bus8.start_ready, 1);
        chk("ab_busy", bus8.busy, 0);
        chk("ab_val", bus8.res_valid, 0);
        chk("ab_eq", bus8.res_eq, 0);
        chk("ab_idx", bus8.res_idx, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("ab_noval", bus8.res_valid, 0);
        end
        run8(8'hC3, 8'hC7); take8();

        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                run2(2'(a), 2'(b));
            end
        end

        chk("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
